mmio_timer_periph: RTL and testbench

- Memory-mapped peripheral block decoded from the data-memory address space when Address[30]=1.
- Holds a reloadable 32-bit timer with an interrupt, an LED register, a 7-segment drive register and a free-running system tick counter.
- Its read data and interrupt are consumed by the data-memory stage; the interrupt line feeds the pipeline's exception logic.

---
 rtl/mmio_timer_periph.sv | 130 +++++++++++++
 tb/tb_mmio_timer_periph.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_periph.sv
// rtl/mmio_timer_periph.sv - memory-mapped reloadable timer, LED, 7-segment and system tick peripheral
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous active-low reset
//   Read       memory-stage read enable
//   Write      memory-stage write enable
//   addr       byte address; hit when addr[31:30]==BASE_HI, word offset addr[4:2]
//   wdata      store data
//   check      debug halt, freezes TL and SYSTICK counting while high
//   rdata      combinational read data (0 unless a hitting read)
//   interrupt  timer interrupt request, the registered TCON irq status bit
//   leds       LED register
//   digi       7-segment register: [11:8] anode select, [7:0] segments
module mmio_timer_periph #(
    parameter logic [1:0] BASE_HI = 2'b01,
    parameter int         LED_W   = 8,
    parameter int         DIGI_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    input  logic              check,
    output logic [31:0]       rdata,
    output logic              interrupt,
    output logic [LED_W-1:0]  leds,
    output logic [DIGI_W-1:0] digi
);

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_DIGI    = 3'd4;
    localparam logic [2:0] OFF_SYSTICK = 3'd5;

    logic [31:0]       th;
    logic [31:0]       tl;
    logic [2:0]        tcon;     // [0] enable, [1] irq enable, [2] irq status
    logic [LED_W-1:0]  led_reg;
    logic [DIGI_W-1:0] digi_reg;
    logic [31:0]       systick;

    logic       hit;
    logic [2:0] off;
    logic       we_th;
    logic       we_tl;
    logic       we_tcon;
    logic       we_led;
    logic       we_digi;
    logic       tick_en;

    assign hit     = (addr[31:30] == BASE_HI);
    assign off     = addr[4:2];
    assign we_th   = Write && hit && (off == OFF_TH);
    assign we_tl   = Write && hit && (off == OFF_TL);
    assign we_tcon = Write && hit && (off == OFF_TCON);
    assign we_led  = Write && hit && (off == OFF_LED);
    assign we_digi = Write && hit && (off == OFF_DIGI);
    assign tick_en = tcon[0] && !check;

    // Software writes are applied after the count/reload assignments so that
    // a write to TL or TCON in the same cycle overrides the hardware update.
    // The reload reads the pre-edge TH, so a TH write on the overflow cycle
    // only affects the following overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            th       <= 32'd0;
            tl       <= 32'd0;
            tcon     <= 3'd0;
            led_reg  <= '0;
            digi_reg <= '0;
            systick  <= 32'd0;
        end else begin
            if (!check) begin
                systick <= systick + 32'd1;
            end

            if (tick_en) begin
                if (tl == 32'hFFFF_FFFF) begin
                    tl <= th;
                    if (tcon[1]) begin
                        tcon[2] <= 1'b1;
                    end
                end else begin
                    tl <= tl + 32'd1;
                end
            end

            if (we_th) begin
                th <= wdata;
            end
            if (we_tl) begin
                tl <= wdata;
            end
            if (we_tcon) begin
                tcon <= wdata[2:0];
            end
            if (we_led) begin
                led_reg <= wdata[LED_W-1:0];
            end
            if (we_digi) begin
                digi_reg <= wdata[DIGI_W-1:0];
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (Read && hit) begin
            case (off)
                OFF_TH:      rdata = th;
                OFF_TL:      rdata = tl;
                OFF_TCON:    rdata = {29'd0, tcon};
                OFF_LED:     rdata = {{(32-LED_W){1'b0}}, led_reg};
                OFF_DIGI:    rdata = {{(32-DIGI_W){1'b0}}, digi_reg};
                OFF_SYSTICK: rdata = systick;
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign interrupt = tcon[2];
    assign leds      = led_reg;
    assign digi      = digi_reg;

endmodule

// File: tb/tb_mmio_timer_periph.sv
// tb/tb_mmio_timer_periph.sv - randomized self-checking bench for mmio_timer_periph
module tb_mmio_timer_periph;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_LED  = 32'h4000_000C;
    localparam logic [31:0] A_DIGI = 32'h4000_0010;
    localparam logic [31:0] A_TICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset;
    logic        Read;
    logic        Write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        check;
    logic [31:0] rdata;
    logic        interrupt;
    logic [7:0]  leds;
    logic [11:0] digi;

    mmio_timer_periph dut (
        .clk       (clk),
        .reset     (reset),
        .Read      (Read),
        .Write     (Write),
        .addr      (addr),
        .wdata     (wdata),
        .check     (check),
        .rdata     (rdata),
        .interrupt (interrupt),
        .leds      (leds),
        .digi      (digi)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: register file indexed by word offset
    // 0 TH, 1 TL, 2 TCON, 3 LED, 4 DIGI, 5 SYSTICK, 6/7 unmapped.
    logic [31:0] m_reg [8];
    logic [31:0] obs_rdata;
    logic [31:0] t0;
    logic [31:0] t1;

    function automatic logic [31:0] reg_mask(input int idx);
        case (idx)
            0, 1, 5: return 32'hFFFF_FFFF;
            2:       return 32'h0000_0007;
            3:       return 32'h0000_00FF;
            4:       return 32'h0000_0FFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        int idx;
        idx = int'(a[4:2]);
        if (!rd || a[31:30] != 2'b01) return 32'h0;
        return m_reg[idx] & reg_mask(idx);
    endfunction

    task automatic model_step(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic chk, input logic rst);
        logic [31:0] old [8];
        int idx;
        if (!rst) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
            return;
        end
        for (int i = 0; i < 8; i++) old[i] = m_reg[i];
        if (!chk) m_reg[5] = old[5] + 32'd1;
        if (old[2][0] && !chk) begin
            if (old[1] == 32'hFFFF_FFFF) begin
                m_reg[1] = old[0];
                if (old[2][1]) m_reg[2] = old[2] | 32'h4;
            end else begin
                m_reg[1] = old[1] + 32'd1;
            end
        end
        idx = int'(a[4:2]);
        if (wr && a[31:30] == 2'b01 && idx < 5) m_reg[idx] = d & reg_mask(idx);
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // One bus cycle: drive inputs, sample rdata mid-cycle, let the edge happen,
    // advance the model, then compare the registered outputs.
    task automatic cycle(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic chk, input logic rst);
        reset = rst;
        Read  = rd;
        Write = wr;
        addr  = a;
        wdata = d;
        check = chk;
        @(negedge clk);
        obs_rdata = rdata;
        check_val("rdata", rdata, model_read(rd, a));
        @(posedge clk);
        model_step(wr, a, d, chk, rst);
        #1;
        check_val("interrupt", {31'd0, interrupt}, {31'd0, m_reg[2][2]});
        check_val("leds", {24'd0, leds}, m_reg[3]);
        check_val("digi", {20'd0, digi}, m_reg[4]);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input logic [31:0] a);
        cycle(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
        reset = 1'b0; Read = 1'b0; Write = 1'b0; addr = 32'h0; wdata = 32'h0; check = 1'b0;
        @(posedge clk);
        #1;

        // Reset dominates a concurrent LED write
        cycle(1'b0, 1'b1, A_LED, 32'hFF, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, A_LED, 32'hFF, 1'b0, 1'b0);
        check_val("rst_leds", {24'd0, leds}, 32'h0);
        check_val("rst_digi", {20'd0, digi}, 32'h0);
        check_val("rst_irq", {31'd0, interrupt}, 32'h0);
        rd_reg(A_TICK);
        check_val("rst_systick", obs_rdata, 32'h0);

        // Overflow with interrupt enabled
        wr_reg(A_TH, 32'hFFFF_FFFC);
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'h3);
        rd_reg(A_TL);
        rd_reg(A_TL);
        check_val("tl_at_max", obs_rdata, 32'hFFFF_FFFF);
        check_val("irq_set", {31'd0, interrupt}, 32'h1);
        rd_reg(A_TL);
        check_val("tl_reload", obs_rdata, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) rd_reg(A_TCON);
        check_val("irq_sticky", {31'd0, interrupt}, 32'h1);
        check_val("tcon_read", obs_rdata, 32'h7);
        wr_reg(A_TCON, 32'h3);
        check_val("irq_clear", {31'd0, interrupt}, 32'h0);

        // Overflow with interrupt disabled
        wr_reg(A_TCON, 32'h0);
        wr_reg(A_TL, 32'hFFFF_FFFE);
        wr_reg(A_TCON, 32'h1);
        rd_reg(A_TL);
        rd_reg(A_TL);
        rd_reg(A_TL);
        check_val("noirq_reload", obs_rdata, 32'hFFFF_FFFC);
        check_val("noirq_irq", {31'd0, interrupt}, 32'h0);

        // TL write on the overflow cycle wins over the reload
        wr_reg(A_TL, 32'hFFFF_FFFE);
        rd_reg(A_TL);
        check_val("pre_ovf", obs_rdata, 32'hFFFF_FFFE);
        wr_reg(A_TL, 32'h10);
        rd_reg(A_TL);
        check_val("wr_priority", obs_rdata, 32'h10);
        check_val("wr_prio_irq", {31'd0, interrupt}, 32'h0);

        // Decode
        wr_reg(A_LED, 32'hA5);
        check_val("led_write", {24'd0, leds}, 32'hA5);
        wr_reg(32'h0000_000C, 32'h5A);
        check_val("led_miss", {24'd0, leds}, 32'hA5);
        rd_reg(32'h4000_0018);
        check_val("unmapped", obs_rdata, 32'h0);
        cycle(1'b0, 1'b0, A_LED, 32'h0, 1'b0, 1'b1);
        check_val("read_off", obs_rdata, 32'h0);
        wr_reg(A_DIGI, 32'hFFFF_FFFF);
        check_val("digi_write", {20'd0, digi}, 32'hFFF);
        rd_reg(A_DIGI);
        check_val("digi_readback", obs_rdata, 32'h0000_0FFF);

        // Debug halt freezes TL and SYSTICK
        wr_reg(A_TCON, 32'h1);
        cycle(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1);
        t0 = obs_rdata;
        cycle(1'b1, 1'b0, A_TICK, 32'h0, 1'b1, 1'b1);
        t1 = obs_rdata;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, A_TL, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, A_TL, 32'h0, 1'b1, 1'b1);
        check_val("halt_tl", obs_rdata, t0);
        cycle(1'b1, 1'b0, A_TICK, 32'h0, 1'b0, 1'b1);
        check_val("halt_tick", obs_rdata, t1);
        rd_reg(A_TICK);
        check_val("resume_tick", obs_rdata, t1 + 32'd1);
        rd_reg(A_TL);
        t0 = obs_rdata;
        rd_reg(A_TL);
        check_val("resume_tl", obs_rdata, t0 + 32'd1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic        rd;
            logic        wr;
            logic        chk;
            logic        rst;
            a        = $urandom;
            a[31:30] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
            rd       = 1'($urandom);
            wr       = ($urandom_range(0, 2) == 0);
            chk      = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 299) != 0);
            d        = $urandom;
            if (a[4:2] == 3'd1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            if (a[4:2] == 3'd2 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
            cycle(rd, wr, a, d, chk, rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
